// File: rtl/noc_endpoint_ni.sv
// rtl/noc_endpoint_ni.sv - mesh NoC endpoint network interface: packetizes TX commands/words and
// depacketizes router flits into delivered body words with source coordinates.
module noc_endpoint_ni #(
    parameter int DATA_WIDTH  = 32,
    parameter int X_DIMENSION = 4,
    parameter int Y_DIMENSION = 4,
    parameter int MAX_LEN     = 8,
    parameter int SOURCE_X    = 0,
    parameter int SOURCE_Y    = 0,
    localparam int X_WIDTH    = $clog2(X_DIMENSION),
    localparam int Y_WIDTH    = $clog2(Y_DIMENSION),
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [X_WIDTH-1:0]    cmd_dest_x_i,
    input  logic [Y_WIDTH-1:0]    cmd_dest_y_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,

    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,

    output logic [DATA_WIDTH-1:0] noc_data_o,
    output logic                  noc_valid_o,
    input  logic                  noc_ready_i,

    input  logic [DATA_WIDTH-1:0] noc_data_i,
    input  logic                  noc_valid_i,
    output logic                  noc_ready_o,

    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  rx_last_o,
    output logic [X_WIDTH-1:0]    rx_src_x_o,
    output logic [Y_WIDTH-1:0]    rx_src_y_o,

    output logic                  err_o
);

    // Header field offsets, LSB first: dest_x, dest_y, src_x, src_y, len.
    localparam int DY_LSB   = X_WIDTH;
    localparam int SX_LSB   = X_WIDTH + Y_WIDTH;
    localparam int SY_LSB   = 2 * X_WIDTH + Y_WIDTH;
    localparam int LEN_LSB  = 2 * X_WIDTH + 2 * Y_WIDTH;
    localparam int HDR_BITS = LEN_LSB + LEN_WIDTH;

    localparam logic [X_WIDTH-1:0]   MY_X    = X_WIDTH'(SOURCE_X);
    localparam logic [Y_WIDTH-1:0]   MY_Y    = Y_WIDTH'(SOURCE_Y);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

    generate
        if (DATA_WIDTH < HDR_BITS) begin : g_width_check
            $error("noc_endpoint_ni: DATA_WIDTH too small for header fields");
        end
    endgenerate

    typedef enum logic [1:0] {T_IDLE, T_HEAD, T_BODY} tx_state_t;
    typedef enum logic       {R_HEAD, R_BODY}         rx_state_t;

    tx_state_t             r_tx_state;
    logic [X_WIDTH-1:0]    r_tx_dest_x;
    logic [Y_WIDTH-1:0]    r_tx_dest_y;
    logic [LEN_WIDTH-1:0]  r_tx_len;
    logic [LEN_WIDTH-1:0]  r_tx_remaining;

    rx_state_t             r_rx_state;
    logic [LEN_WIDTH-1:0]  r_rx_remaining;
    logic [X_WIDTH-1:0]    r_rx_src_x;
    logic [Y_WIDTH-1:0]    r_rx_src_y;

    logic                  r_err;

    logic [DATA_WIDTH-1:0] w_tx_header;
    logic                  w_cmd_len_ok;
    logic                  w_tx_err;
    logic [X_WIDTH-1:0]    w_in_dest_x;
    logic [Y_WIDTH-1:0]    w_in_dest_y;
    logic [X_WIDTH-1:0]    w_in_src_x;
    logic [Y_WIDTH-1:0]    w_in_src_y;
    logic [LEN_WIDTH-1:0]  w_in_len;
    logic                  w_in_len_ok;
    logic                  w_rx_err;

    assign w_cmd_len_ok = (cmd_len_i != '0) && (cmd_len_i <= LEN_MAX);
    assign w_tx_err     = (r_tx_state == T_IDLE) && cmd_valid_i && !w_cmd_len_ok;

    assign w_in_dest_x  = noc_data_i[0 +: X_WIDTH];
    assign w_in_dest_y  = noc_data_i[DY_LSB +: Y_WIDTH];
    assign w_in_src_x   = noc_data_i[SX_LSB +: X_WIDTH];
    assign w_in_src_y   = noc_data_i[SY_LSB +: Y_WIDTH];
    assign w_in_len     = noc_data_i[LEN_LSB +: LEN_WIDTH];
    assign w_in_len_ok  = (w_in_len != '0) && (w_in_len <= LEN_MAX);
    // A misrouted header is flagged but still delivered; only a bad length drops it.
    assign w_rx_err     = (r_rx_state == R_HEAD) && noc_valid_i &&
                          (!w_in_len_ok || (w_in_dest_x != MY_X) || (w_in_dest_y != MY_Y));

    always_comb begin
        w_tx_header                        = '0;
        w_tx_header[0 +: X_WIDTH]          = r_tx_dest_x;
        w_tx_header[DY_LSB +: Y_WIDTH]     = r_tx_dest_y;
        w_tx_header[SX_LSB +: X_WIDTH]     = MY_X;
        w_tx_header[SY_LSB +: Y_WIDTH]     = MY_Y;
        w_tx_header[LEN_LSB +: LEN_WIDTH]  = r_tx_len;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_state     <= T_IDLE;
            r_tx_dest_x    <= '0;
            r_tx_dest_y    <= '0;
            r_tx_len       <= '0;
            r_tx_remaining <= '0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (cmd_valid_i && w_cmd_len_ok) begin
                        r_tx_dest_x <= cmd_dest_x_i;
                        r_tx_dest_y <= cmd_dest_y_i;
                        r_tx_len    <= cmd_len_i;
                        r_tx_state  <= T_HEAD;
                    end
                end
                T_HEAD: begin
                    if (noc_ready_i) begin
                        r_tx_remaining <= r_tx_len;
                        r_tx_state     <= T_BODY;
                    end
                end
                T_BODY: begin
                    if (tx_valid_i && noc_ready_i) begin
                        r_tx_remaining <= r_tx_remaining - 1'b1;
                        if (r_tx_remaining == LEN_WIDTH'(1)) begin
                            r_tx_state <= T_IDLE;
                        end
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_state     <= R_HEAD;
            r_rx_remaining <= '0;
            r_rx_src_x     <= '0;
            r_rx_src_y     <= '0;
        end else begin
            case (r_rx_state)
                R_HEAD: begin
                    if (noc_valid_i && w_in_len_ok) begin
                        r_rx_src_x     <= w_in_src_x;
                        r_rx_src_y     <= w_in_src_y;
                        r_rx_remaining <= w_in_len;
                        r_rx_state     <= R_BODY;
                    end
                end
                R_BODY: begin
                    if (noc_valid_i && rx_ready_i) begin
                        r_rx_remaining <= r_rx_remaining - 1'b1;
                        if (r_rx_remaining == LEN_WIDTH'(1)) begin
                            r_rx_state <= R_HEAD;
                        end
                    end
                end
                default: r_rx_state <= R_HEAD;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_tx_err || w_rx_err) begin
            r_err <= 1'b1;
        end
    end

    // Body phases are pure pass-through so a stalled router back-pressures the source directly.
    always_comb begin
        noc_valid_o = 1'b0;
        noc_data_o  = '0;
        tx_ready_o  = 1'b0;
        case (r_tx_state)
            T_HEAD: begin
                noc_valid_o = 1'b1;
                noc_data_o  = w_tx_header;
            end
            T_BODY: begin
                noc_valid_o = tx_valid_i;
                noc_data_o  = tx_data_i;
                tx_ready_o  = noc_ready_i;
            end
            default: ;
        endcase
    end

    assign cmd_ready_o = (r_tx_state == T_IDLE);

    assign noc_ready_o = (r_rx_state == R_HEAD) ? 1'b1 : rx_ready_i;
    assign rx_valid_o  = (r_rx_state == R_BODY) && noc_valid_i;
    assign rx_data_o   = noc_data_i;
    assign rx_last_o   = (r_rx_state == R_BODY) && (r_rx_remaining == LEN_WIDTH'(1));
    assign rx_src_x_o  = r_rx_src_x;
    assign rx_src_y_o  = r_rx_src_y;
    assign err_o       = r_err;

endmodule

// File: tb/tb_noc_endpoint_ni.sv
// tb/tb_noc_endpoint_ni.sv - randomized scoreboard bench for noc_endpoint_ni at node (1,2).
module tb_noc_endpoint_ni;

    localparam int DW = 32;
    localparam int XD = 4;
    localparam int YD = 4;
    localparam int ML = 8;
    localparam int SX = 1;
    localparam int SY = 2;
    localparam int XW = $clog2(XD);
    localparam int YW = $clog2(YD);
    localparam int LW = $clog2(ML + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [XW-1:0] cmd_dest_x_i = '0;
    logic [YW-1:0] cmd_dest_y_i = '0;
    logic [LW-1:0] cmd_len_i = '0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o;
    logic [DW-1:0] noc_data_o;
    logic          noc_valid_o;
    logic          noc_ready_i = 1'b1;
    logic [DW-1:0] noc_data_i = '0;
    logic          noc_valid_i = 1'b0;
    logic          noc_ready_o;
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b1;
    logic          rx_last_o;
    logic [XW-1:0] rx_src_x_o;
    logic [YW-1:0] rx_src_y_o;
    logic          err_o;

    noc_endpoint_ni #(
        .DATA_WIDTH(DW), .X_DIMENSION(XD), .Y_DIMENSION(YD), .MAX_LEN(ML),
        .SOURCE_X(SX), .SOURCE_Y(SY)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_dest_x_i(cmd_dest_x_i), .cmd_dest_y_i(cmd_dest_y_i), .cmd_len_i(cmd_len_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .noc_data_o(noc_data_o), .noc_valid_o(noc_valid_o), .noc_ready_i(noc_ready_i),
        .noc_data_i(noc_data_i), .noc_valid_i(noc_valid_i), .noc_ready_o(noc_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .rx_last_o(rx_last_o), .rx_src_x_o(rx_src_x_o), .rx_src_y_o(rx_src_y_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_err  = 1'b0;
    bit          mon_en   = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [DW-1:0] exp_noc[$];
    logic [63:0]   exp_rx[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_header(input int dx, input int dy, input int sx,
                                                  input int sy, input int len);
        return DW'(dx + dy * (2 ** XW) + sx * (2 ** (XW + YW)) + sy * (2 ** (2 * XW + YW))
                   + len * (2 ** (2 * XW + 2 * YW)));
    endfunction

    function automatic logic [63:0] pack_rx(input logic [DW-1:0] data, input int sx,
                                            input int sy, input bit last);
        return 64'(data) + 64'(sy) * (64'd1 << DW) + 64'(sx) * (64'd1 << (DW + YW))
               + 64'(last) * (64'd1 << (DW + YW + XW));
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return cmd_ready_o;
            1:       return tx_ready_o;
            default: return noc_ready_o;
        endcase
    endfunction

    task automatic wait_accept(input int sel, input string tag);
        int   n = 0;
        logic acc;
        do begin
            @(negedge clk_i);
            acc = ready_of(sel);
            @(posedge clk_i);
            #1;
            n++;
        end while (!acc && n < 300);
        check_eq({tag, "_accepted"}, 64'(acc), 64'd1);
    endtask

    task automatic send_cmd(input int dx, input int dy, input int len);
        cmd_dest_x_i = XW'(dx);
        cmd_dest_y_i = YW'(dy);
        cmd_len_i    = LW'(len);
        cmd_valid_i  = 1'b1;
        wait_accept(0, "cmd");
        cmd_valid_i  = 1'b0;
    endtask

    task automatic send_tx(input logic [DW-1:0] data);
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        wait_accept(1, "tx");
        tx_valid_i = 1'b0;
    endtask

    task automatic send_noc(input logic [DW-1:0] data);
        noc_data_i  = data;
        noc_valid_i = 1'b1;
        wait_accept(2, "noc_in");
        noc_valid_i = 1'b0;
    endtask

    task automatic idle_gap();
        int n = $urandom_range(0, 2);
        if (n > 0) begin
            repeat (n) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic tx_packet(input int dx, input int dy, input int len);
        logic [DW-1:0] words[$];
        bit bad = (len == 0) || (len > ML);
        if (bad) begin
            exp_err = 1'b1;
        end else begin
            exp_noc.push_back(make_header(dx, dy, SX, SY, len));
            for (int i = 0; i < len; i++) begin
                words.push_back($urandom);
                exp_noc.push_back(words[i]);
            end
        end
        send_cmd(dx, dy, len);
        foreach (words[i]) begin
            idle_gap();
            send_tx(words[i]);
        end
    endtask

    task automatic rx_packet(input int sx, input int sy, input int dx, input int dy, input int len);
        logic [DW-1:0] w;
        bit bad = (len == 0) || (len > ML);
        if (bad || dx != SX || dy != SY) exp_err = 1'b1;
        send_noc(make_header(dx, dy, sx, sy, len));
        if (!bad) begin
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                exp_rx.push_back(pack_rx(w, sx, sy, i == len - 1));
                idle_gap();
                send_noc(w);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_rdy) begin
                noc_ready_i = ($urandom_range(0, 3) != 0);
                rx_ready_i  = $urandom_range(0, 1) != 0;
            end
        end
    end

    // Scoreboard: every accepted flit on either side must be the next one the model expects.
    initial begin
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        forever begin
            @(negedge clk_i);
            if (mon_en && !rst_i) begin
                if (prev_stall) begin
                    check_eq("noc_hold_valid", 64'(noc_valid_o), 64'd1);
                    check_eq("noc_hold_data", 64'(noc_data_o), 64'(prev_data));
                end
                if (!noc_ready_i && tx_valid_i)
                    check_eq("tx_ready_stall", 64'(tx_ready_o), 64'd0);
                if (noc_valid_o && noc_ready_i) begin
                    check_eq("noc_flit_expected", 64'(exp_noc.size() != 0), 64'd1);
                    if (exp_noc.size() != 0)
                        check_eq("noc_flit", 64'(noc_data_o), 64'(exp_noc.pop_front()));
                end
                if (rx_valid_o && rx_ready_i) begin
                    check_eq("rx_word_expected", 64'(exp_rx.size() != 0), 64'd1);
                    if (exp_rx.size() != 0)
                        check_eq("rx_word", pack_rx(rx_data_o, int'(rx_src_x_o), int'(rx_src_y_o),
                                                    rx_last_o), exp_rx.pop_front());
                end
                prev_stall = noc_valid_o && !noc_ready_i;
                prev_data  = noc_data_o;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("rst_tx_ready", 64'(tx_ready_o), 64'd0);
        check_eq("rst_noc_valid", 64'(noc_valid_o), 64'd0);
        check_eq("rst_noc_ready", 64'(noc_ready_o), 64'd1);
        check_eq("rst_rx_valid", 64'(rx_valid_o), 64'd0);
        check_eq("rst_rx_last", 64'(rx_last_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
        check_eq("rst_rx_src", 64'({rx_src_x_o, rx_src_y_o}), 64'd0);
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;

        // Basic packet with the router always ready: header the cycle after cmd.
        noc_ready_i = 1'b1;
        exp_noc.push_back(make_header(3, 0, SX, SY, 2));
        exp_noc.push_back(32'hAAAA_0001);
        exp_noc.push_back(32'hBBBB_0002);
        send_cmd(3, 0, 2);
        @(negedge clk_i);
        check_eq("hdr_valid_next_cycle", 64'(noc_valid_o), 64'd1);
        check_eq("hdr_value", 64'(noc_data_o), 64'h293);
        check_eq("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        send_tx(32'hAAAA_0001);
        send_tx(32'hBBBB_0002);
        @(negedge clk_i);
        check_eq("tx_back_idle", 64'(cmd_ready_o), 64'd1);
        @(posedge clk_i);
        #1;

        // Same packet with router stalls on the header and on word B.
        noc_ready_i = 1'b0;
        exp_noc.push_back(make_header(3, 0, SX, SY, 2));
        exp_noc.push_back(32'hAAAA_0001);
        exp_noc.push_back(32'hBBBB_0002);
        send_cmd(3, 0, 2);
        tx_data_i  = 32'hAAAA_0001;
        tx_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check_eq("hdr_stall_data", 64'(noc_data_o), 64'h293);
            check_eq("hdr_stall_tx_ready", 64'(tx_ready_o), 64'd0);
            @(posedge clk_i);
            #1;
        end
        noc_ready_i = 1'b1;
        send_tx(32'hAAAA_0001);
        noc_ready_i = 1'b0;
        tx_data_i   = 32'hBBBB_0002;
        tx_valid_i  = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check_eq("body_stall_data", 64'(noc_data_o), 64'hBBBB_0002);
            @(posedge clk_i);
            #1;
        end
        noc_ready_i = 1'b1;
        send_tx(32'hBBBB_0002);
        check_eq("stall_all_flits_out", 64'(exp_noc.size()), 64'd0);

        // Directed RX packet with rx_ready toggling.
        rand_rdy = 1'b1;
        rx_packet(2, 3, SX, SY, 3);
        check_eq("rx_src_held", 64'({rx_src_x_o, rx_src_y_o}), 64'({2'd2, 2'd3}));
        check_eq("rx_err_clean", 64'(err_o), 64'd0);

        // Random concurrent TX and RX traffic.
        fork
            for (int p = 0; p < 12; p++) begin
                idle_gap();
                tx_packet($urandom_range(0, XD - 1), $urandom_range(0, YD - 1), $urandom_range(1, ML));
            end
            for (int q = 0; q < 12; q++) begin
                idle_gap();
                rx_packet($urandom_range(0, XD - 1), $urandom_range(0, YD - 1), SX, SY,
                          $urandom_range(1, ML));
            end
        join
        check_eq("rand_tx_drained", 64'(exp_noc.size()), 64'd0);
        check_eq("rand_rx_drained", 64'(exp_rx.size()), 64'd0);
        check_eq("rand_err", 64'(err_o), 64'(exp_err));

        // Protocol errors: bad cmd lengths, zero-length header, misrouted header.
        tx_packet(2, 1, 0);
        tx_packet(0, 3, 9);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("cmd_len_err", 64'(err_o), 64'(exp_err));
        check_eq("cmd_len_err_idle", 64'(cmd_ready_o), 64'd1);
        rx_packet(0, 0, SX, SY, 0);
        rx_packet(3, 3, SX, SY, 1);
        check_eq("rx_len_err_sticky", 64'(err_o), 64'(exp_err));
        rx_packet(3, 1, 0, 0, 1);
        check_eq("rx_dest_err", 64'(err_o), 64'd1);
        check_eq("err_tx_drained", 64'(exp_noc.size()), 64'd0);
        check_eq("err_rx_drained", 64'(exp_rx.size()), 64'd0);

        // Reset in the middle of a TX body and an RX body.
        rand_rdy = 1'b0;
        mon_en   = 1'b0;
        #1;
        noc_ready_i = 1'b1;
        rx_ready_i  = 1'b1;
        send_cmd(2, 2, 4);
        send_noc(make_header(SX, SY, 1, 1, 3));
        send_tx(32'h1111_0000);
        send_noc(32'h2222_0000);
        tx_data_i   = 32'h1111_0001;
        tx_valid_i  = 1'b1;
        noc_data_i  = 32'h2222_0001;
        noc_valid_i = 1'b1;
        rst_i       = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        tx_valid_i  = 1'b0;
        noc_valid_i = 1'b0;
        exp_noc.delete();
        exp_rx.delete();
        exp_err = 1'b0;
        @(negedge clk_i);
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("mid_rst_tx_ready", 64'(tx_ready_o), 64'd0);
        check_eq("mid_rst_noc_valid", 64'(noc_valid_o), 64'd0);
        check_eq("mid_rst_noc_ready", 64'(noc_ready_o), 64'd1);
        check_eq("mid_rst_rx_valid", 64'(rx_valid_o), 64'd0);
        check_eq("mid_rst_rx_last", 64'(rx_last_o), 64'd0);
        check_eq("mid_rst_err", 64'(err_o), 64'd0);
        check_eq("mid_rst_rx_src", 64'({rx_src_x_o, rx_src_y_o}), 64'd0);
        @(posedge clk_i);
        #1;
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        fork
            tx_packet(3, 3, 2);
            rx_packet(0, 1, SX, SY, 2);
        join
        check_eq("post_rst_tx_drained", 64'(exp_noc.size()), 64'd0);
        check_eq("post_rst_rx_drained", 64'(exp_rx.size()), 64'd0);
        check_eq("post_rst_err", 64'(err_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
